uart_tx_arb: RTL and testbench

- Round-robin, packet-granular arbiter that shares the single UART transmit byte stream (TX FIFO push side) between `NUM_REQ` requesters.
- Sits between software/DMA byte sources and the TX FIFO push interface.
- Holds a grant until the requester marks its last byte or a per-grant burst limit is reached, so short messages are never interleaved.
- Drives the FIFO through a one-deep registered output stage.

---
 rtl/uart_arb_pkg.sv | 44 ++++
 rtl/uart_rr_pick.sv | 32 +++
 rtl/uart_tx_arb.sv | 137 +++++++++++++
 tb/tb_uart_tx_arb.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_arb_pkg
// Description : Shared types and the rotating-priority pick function for the
//               UART TX packet arbiter.
// Revision    : 1.0  initial release
// ============================================================================
package uart_arb_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    localparam int UART_ARB_MAX_REQ = 8;
    localparam int UART_ARB_IDX_W   = 3;

    typedef struct packed {
        logic                      found;
        logic [UART_ARB_IDX_W-1:0] idx;
    } rr_pick_t;

    // Requester slots above the real count are tied low by the caller, so a
    // modulo-8 scan visits live requesters in the same order as modulo NUM_REQ.
    function automatic rr_pick_t rr_pick(
        input logic [UART_ARB_MAX_REQ-1:0] valid,
        input logic [UART_ARB_IDX_W-1:0]   ptr
    );
        rr_pick_t                  res;
        logic [UART_ARB_IDX_W-1:0] k;
        res = '0;
        for (int i = 1; i <= UART_ARB_MAX_REQ; i++) begin
            k = ptr + UART_ARB_IDX_W'(i);
            if (!res.found && valid[k]) begin
                res.found = 1'b1;
                res.idx   = k;
            end
        end
        return res;
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rr_pick.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_rr_pick
// Description : Combinational rotating-priority encoder; first request above
//               ptr_i, wrapping modulo NUM_REQ.
// Revision    : 1.0  initial release
// ============================================================================
module uart_rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [2:0]         ptr_i,
    output logic [2:0]         idx_o,
    output logic               found_o
);
    import uart_arb_pkg::*;

    logic [UART_ARB_MAX_REQ-1:0] req_ext;
    rr_pick_t                    pick;

    always_comb begin
        req_ext              = '0;
        req_ext[NUM_REQ-1:0] = req_i;
        pick                 = rr_pick(req_ext, ptr_i);
    end

    assign idx_o   = pick.idx;
    assign found_o = pick.found;

endmodule
`default_nettype wire

// File: rtl/uart_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_tx_arb
// Description : Packet-granular round-robin arbiter feeding the UART TX FIFO
//               push port through a one-deep registered output stage.
// Revision    : 1.0  initial release
// ============================================================================
module uart_tx_arb #(
    parameter int NUM_REQ   = 4,
    parameter int MAX_BURST = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [NUM_REQ*8-1:0] req_data_i,
    input  logic [NUM_REQ-1:0]   req_last_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic                 tx_valid_o,
    output logic [7:0]           tx_data_o,
    input  logic                 tx_ready_i,
    output logic [NUM_REQ-1:0]   grant_o,
    output logic                 busy_o
);
    import uart_arb_pkg::*;

    localparam int CNT_W = (MAX_BURST == 0) ? 8 : $clog2(MAX_BURST + 1);
    localparam logic [UART_ARB_IDX_W-1:0] PTR_RST = UART_ARB_IDX_W'(NUM_REQ - 1);

    arb_state_e                state_q;
    logic [UART_ARB_IDX_W-1:0] owner_q;
    logic [UART_ARB_IDX_W-1:0] ptr_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [CNT_W-1:0]          cnt_d;
    logic [NUM_REQ-1:0]        grant_q;
    logic                      busy_q;
    logic                      out_valid_q;
    logic [7:0]                out_data_q;

    logic [UART_ARB_IDX_W-1:0] pick_idx;
    logic                      pick_found;
    logic [NUM_REQ-1:0]        ready;
    logic                      hs;
    logic [7:0]                owner_data;
    logic                      owner_last;
    logic                      burst_hit;

    uart_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req_i   (req_valid_i),
        .ptr_i   (ptr_q),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    // grant_q is zero outside XFER, so ready needs no state decode here.
    assign ready = grant_q & {NUM_REQ{~out_valid_q | tx_ready_i}};
    assign hs    = |(ready & req_valid_i);

    always_comb begin
        owner_data = 8'h00;
        owner_last = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (owner_q == UART_ARB_IDX_W'(k)) begin
                owner_data = req_data_i[k*8 +: 8];
                owner_last = req_last_i[k];
            end
        end
    end

    always_comb begin
        if (MAX_BURST == 0 && cnt_q == {CNT_W{1'b1}}) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    assign burst_hit = (MAX_BURST != 0) && (cnt_d == CNT_W'(MAX_BURST));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            ptr_q       <= PTR_RST;
            cnt_q       <= '0;
            grant_q     <= '0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= 8'h00;
        end else begin
            if (hs) begin
                out_valid_q <= 1'b1;
                out_data_q  <= owner_data;
            end else if (tx_ready_i) begin
                out_valid_q <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (pick_found) begin
                        state_q <= XFER;
                        owner_q <= pick_idx;
                        cnt_q   <= '0;
                        grant_q <= NUM_REQ'(1) << pick_idx;
                        busy_q  <= 1'b1;
                    end
                end
                XFER: begin
                    if (hs) begin
                        cnt_q <= cnt_d;
                        if (owner_last || burst_hit) begin
                            state_q <= IDLE;
                            ptr_q   <= owner_q;
                            grant_q <= '0;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    grant_q <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign req_ready_o = ready;
    assign tx_valid_o  = out_valid_q;
    assign tx_data_o   = out_data_q;
    assign grant_o     = grant_q;
    assign busy_o      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_arb.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx_arb
// Description : Randomized bench for uart_tx_arb against a packet-level
//               round-robin reference model.
// Revision    : 1.0  initial release
// ============================================================================
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int MB = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [N-1:0]   req_valid;
    logic [N*8-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_valid;
    logic [7:0]     tx_data;
    logic           tx_ready;
    logic [N-1:0]   grant;
    logic           busy;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .NUM_REQ   (N),
        .MAX_BURST (MB)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_last_i  (req_last),
        .req_ready_o (req_ready),
        .tx_valid_o  (tx_valid),
        .tx_data_o   (tx_data),
        .tx_ready_i  (tx_ready),
        .grant_o     (grant),
        .busy_o      (busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Per-requester byte streams: bit 8 marks the last byte of a packet.
    logic [8:0] src_q [N][$];
    logic [7:0] exp_bytes[$];
    int         exp_grants[$];
    int         m_ptr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic chk_reset();
        check_eq("rst_grant", grant, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_ready", req_ready, 0);
        check_eq("rst_txv", tx_valid, 0);
        check_eq("rst_txd", tx_data, 0);
    endtask

    function automatic bit all_empty();
        for (int k = 0; k < N; k++) if (src_q[k].size() != 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic push_pkt(input int k, input int len, input logic [7:0] base, input bit rnd);
        logic [7:0] b;
        for (int i = 0; i < len; i++) begin
            b = rnd ? 8'($urandom) : base + 8'(i);
            src_q[k].push_back({(i == len - 1), b});
        end
    endtask

    // Grant order and byte stream follow from the queued packets alone: every
    // requester with bytes left is valid whenever the arbiter is idle.
    task automatic model_build();
        logic [8:0] tmp [N][$];
        logic [8:0] b;
        int g, cnt;
        bit any;
        for (int k = 0; k < N; k++) tmp[k] = src_q[k];
        while (1) begin
            any = 1'b0;
            g = 0;
            for (int i = 1; i <= N; i++) begin
                if (!any && tmp[(m_ptr + i) % N].size() != 0) begin
                    any = 1'b1;
                    g = (m_ptr + i) % N;
                end
            end
            if (!any) break;
            exp_grants.push_back(g);
            cnt = 0;
            do begin
                b = tmp[g].pop_front();
                exp_bytes.push_back(b[7:0]);
                cnt++;
            end while (!b[8] && !(MB != 0 && cnt == MB) && tmp[g].size() != 0);
            m_ptr = g;
        end
    endtask

    task automatic drive_inputs(input int p_ready, input int p_bubble);
        tx_ready = ($urandom_range(99) < p_ready);
        for (int k = 0; k < N; k++) begin
            if (src_q[k].size() != 0) begin
                req_valid[k]       = !(grant[k] && ($urandom_range(99) < p_bubble));
                req_data[k*8 +: 8] = src_q[k][0][7:0];
                req_last[k]        = src_q[k][0][8];
            end else begin
                req_valid[k]       = 1'b0;
                req_data[k*8 +: 8] = 8'($urandom);
                req_last[k]        = 1'($urandom);
            end
        end
    endtask

    // Entered and left just after a rising edge with the arbiter idle.
    task automatic run(input int p_ready, input int p_bubble, input int max_cyc);
        logic [N-1:0] g_prev;
        logic         acc_any, acc_last, stall_prev, rel_pend, arb_pend, done;
        logic [7:0]   acc_byte, stall_byte;
        logic [31:0]  eg;
        int           acc_idx, gcount, tx_seen, gr_seen, tx_total, gr_total;
        model_build();
        tx_total = exp_bytes.size();
        gr_total = exp_grants.size();
        g_prev = grant; acc_any = 0; acc_last = 0; stall_prev = 0; rel_pend = 0;
        arb_pend = 0; done = 0; acc_byte = 0; stall_byte = 0; acc_idx = 0;
        gcount = 0; tx_seen = 0; gr_seen = 0;
        drive_inputs(p_ready, p_bubble);
        for (int cyc = 0; cyc < max_cyc && !done; cyc++) begin
            @(negedge clk);
            if (acc_any) begin
                check_eq("lat_valid", tx_valid, 1);
                check_eq("lat_data", tx_data, acc_byte);
            end
            if (stall_prev) begin
                check_eq("stall_valid", tx_valid, 1);
                check_eq("stall_data", tx_data, stall_byte);
            end
            if (rel_pend) check_eq("release", grant, 0);
            if (arb_pend) check_eq("arb_latency", grant != 0, 1);
            check_eq("ready_mask", req_ready & ~grant, 0);
            check_eq("grant_onehot", $onehot0(grant), 1);
            check_eq("busy", busy, grant != 0);
            if (grant != 0 && tx_ready) check_eq("ready_owner", |(req_ready & grant), 1);
            if (tx_valid && !tx_ready) check_eq("ready_stall", req_ready, 0);
            if (grant != 0 && g_prev == 0) begin
                gcount = 0;
                gr_seen++;
                if (exp_grants.size() != 0) begin
                    eg = 32'(1) << exp_grants.pop_front();
                    check_eq("grant_seq", grant, eg);
                end
            end
            if (tx_valid && tx_ready) begin
                tx_seen++;
                if (exp_bytes.size() != 0) check_eq("tx_byte", tx_data, exp_bytes.pop_front());
            end
            acc_any = 0;
            acc_last = 0;
            for (int k = 0; k < N; k++) begin
                if (req_valid[k] && req_ready[k]) begin
                    acc_any  = 1;
                    acc_idx  = k;
                    acc_byte = req_data[k*8 +: 8];
                    acc_last = req_last[k];
                end
            end
            if (acc_any) gcount++;
            rel_pend   = acc_any && (acc_last || (MB != 0 && gcount == MB));
            arb_pend   = (grant == 0) && (req_valid != 0);
            stall_prev = tx_valid && !tx_ready;
            stall_byte = tx_data;
            g_prev     = grant;
            @(posedge clk); #1;
            if (acc_any) void'(src_q[acc_idx].pop_front());
            drive_inputs(p_ready, p_bubble);
            done = all_empty() && exp_bytes.size() == 0 && grant == 0 && !tx_valid;
        end
        check_eq("run_done", done, 1);
        check_eq("tx_count", tx_seen, tx_total);
        check_eq("grant_count", gr_seen, gr_total);
        exp_bytes.delete();
        exp_grants.delete();
        for (int k = 0; k < N; k++) src_q[k].delete();
        req_valid = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_data = '0; req_last = '0; tx_ready = 1'b0;
        m_ptr = N - 1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        tx_ready = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_eq("idle_grant", grant, 0);
            check_eq("idle_txv", tx_valid, 0);
            check_eq("idle_ready", req_ready, 0);
        end
        @(posedge clk); #1;

        // Requester 2: short three-byte message.
        src_q[2].push_back(9'h041);
        src_q[2].push_back(9'h042);
        src_q[2].push_back(9'h143);
        run(100, 0, 50);

        // Requester 3 long packet split by the burst limit, requester 0 pending.
        push_pkt(3, 20, 8'h80, 0);
        push_pkt(0, 3, 8'h10, 0);
        run(100, 0, 200);

        // Requesters 0 and 1 streaming single-byte packets.
        for (int i = 0; i < 4; i++) begin
            push_pkt(0, 1, 8'hA0 + 8'(i), 0);
            push_pkt(1, 1, 8'hB0 + 8'(i), 0);
        end
        run(100, 0, 100);

        // Heavy backpressure.
        push_pkt(1, 8, 8'h20, 0);
        push_pkt(2, 5, 8'h30, 0);
        run(30, 0, 500);

        // Random traffic with owner bubbles and random FIFO stalls.
        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < N; k++) begin
                for (int p = 0, np = $urandom_range(0, 3); p < np; p++) begin
                    push_pkt(k, $urandom_range(1, 20), 8'h00, 1);
                end
            end
            run($urandom_range(40, 100), 25, 3000);
        end

        // Owner stalls mid-packet while requester 1 waits; then reset.
        req_valid = 4'b0001; req_data = '0; req_data[7:0] = 8'h55; req_last = '0;
        tx_ready = 1'b1;
        @(negedge clk);
        check_eq("hold_idle", grant, 0);
        @(posedge clk); #1;
        @(negedge clk);
        check_eq("hold_grant0", grant, 4'b0001);
        check_eq("hold_rdy0", req_ready[0], 1);
        @(posedge clk); #1;
        req_valid = 4'b0010; req_data[15:8] = 8'h66; req_last = 4'b0010; tx_ready = 1'b0;
        repeat (5) begin
            @(negedge clk);
            check_eq("hold_grant", grant, 4'b0001);
            check_eq("hold_rdy1", req_ready[1], 0);
            check_eq("hold_txv", tx_valid, 1);
            check_eq("hold_txd", tx_data, 8'h55);
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req_valid = '0; req_last = '0; tx_ready = 1'b1;
        @(negedge clk);
        chk_reset();
        @(posedge clk); #1;
        m_ptr = N - 1;

        // Pointer restored by reset: requester 0 wins first.
        for (int k = 0; k < N; k++) push_pkt(k, 1, 8'hC0 + 8'(k), 0);
        run(100, 0, 100);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
